// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the mini-MIPS multi-cycle control unit.
//   - opcode values decoded in DECODE
//   - ALUOp / ALUSrcB / PCSource encodings driven to the datapath
//   - control FSM state enum and trap cause codes
//   - ctrl_t bundles every controller output so it can be defaulted to zero as a unit
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADDR, MEMRD, MEMWB, MEMWR,
        REXEC, IEXEC, ALUWB, BRANCH, JUMP, TRAP
    } state_t;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       PCCondNe;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       MemtoReg;
        logic       RegWrite;
        logic       RegDst;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic [1:0] PCSource;
        logic       instr_done;
        logic       trap;
        logic [1:0] trap_cause;
    } ctrl_t;

    // States that wait on mem_ready and are therefore guarded by the wait timer.
    function automatic logic is_mem_state(state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: bundle between the multi-cycle controller and the datapath.
//   master modport: controller side (status inputs, control outputs)
//   slave modport : datapath side (drives run/opcode/zero/mem_ready, consumes controls)
interface mips_mc_ctrl_if #(
    parameter int OPW = 6
);
    logic           run;
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;

    logic           PCWrite;
    logic           PCWriteCond;
    logic           PCCondNe;
    logic           IorD;
    logic           MemRead;
    logic           MemWrite;
    logic           IRWrite;
    logic           MemtoReg;
    logic           RegWrite;
    logic           RegDst;
    logic           ALUSrcA;
    logic [1:0]     ALUSrcB;
    logic [1:0]     ALUOp;
    logic [1:0]     PCSource;
    logic           instr_done;
    logic           trap;
    logic [1:0]     trap_cause;

    modport master (
        input  run, opcode, zero, mem_ready,
        output PCWrite, PCWriteCond, PCCondNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done, trap, trap_cause
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  PCWrite, PCWriteCond, PCCondNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done, trap, trap_cause
    );
endinterface

// File: rtl/mips_mc_wait_timer.sv
// mips_mc_wait_timer: counts memory wait cycles.
//   clk, rst : clock and synchronous active-high reset
//   clr      : zero the count (asserted on entry to a memory state)
//   en       : count this cycle (memory state with mem_ready low)
//   expired  : this is the last permitted wait cycle; another miss traps
module mips_mc_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    // count_reg holds the misses already seen; the miss that would make it
    // TIMEOUT is the one that traps, so flag one below the limit.
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LIMIT);
endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: Moore multi-cycle control unit for the mini-MIPS core.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mips_mc_ctrl_if.master -- run/opcode/zero/mem_ready in,
//              datapath controls, instr_done, trap and trap_cause out
// Outputs decode from the registered state; the exceptions are the FETCH
// IRWrite/PCWrite strobes and the MEMWR completion pulse (both gated by
// mem_ready) and PCCondNe, which reads the opcode held in the IR.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int OPW         = 6
) (
    input  logic            clk,
    input  logic            rst,
    mips_mc_ctrl_if.master  bus
);
    state_t     state_reg, state_next;
    logic       regdst_reg, regdst_next;
    logic [1:0] cause_reg, cause_next;
    ctrl_t      ctl;
    logic [5:0] op;
    logic       wait_clr, wait_en, wait_expired;
    logic       unused_zero;

    assign op = 6'(bus.opcode);
    // The branch decision uses zero in the datapath PC-write logic.
    assign unused_zero = bus.zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            regdst_reg <= 1'b0;
            cause_reg  <= CAUSE_NONE;
        end else begin
            state_reg  <= state_next;
            regdst_reg <= regdst_next;
            cause_reg  <= cause_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        regdst_next = regdst_reg;
        cause_next  = cause_reg;
        ctl         = '0;
        case (state_reg)
            IDLE: if (bus.run) state_next = FETCH;
            FETCH: begin
                ctl.MemRead = 1'b1;
                ctl.ALUSrcB = SRCB_FOUR;
                ctl.IRWrite = bus.mem_ready;
                ctl.PCWrite = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_next = DECODE;
                end else if (wait_expired) begin
                    state_next = TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            DECODE: begin
                // Precompute the branch target into ALUOut.
                ctl.ALUSrcB = SRCB_IMMSH;
                case (op)
                    OP_RTYPE:                    state_next = REXEC;
                    OP_LW, OP_SW:                state_next = MEMADDR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
                    OP_LUI, OP_SLTI, OP_SLTIU:   state_next = IEXEC;
                    OP_BEQ, OP_BNE:              state_next = BRANCH;
                    OP_J:                        state_next = JUMP;
                    default: begin
                        state_next = TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            MEMADDR: begin
                ctl.ALUSrcA = 1'b1;
                ctl.ALUSrcB = SRCB_IMM;
                state_next  = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                ctl.MemRead = 1'b1;
                ctl.IorD    = 1'b1;
                if (bus.mem_ready) begin
                    state_next = MEMWB;
                end else if (wait_expired) begin
                    state_next = TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            MEMWB: begin
                ctl.RegWrite   = 1'b1;
                ctl.MemtoReg   = 1'b1;
                ctl.instr_done = 1'b1;
                state_next     = FETCH;
            end
            MEMWR: begin
                ctl.MemWrite   = 1'b1;
                ctl.IorD       = 1'b1;
                ctl.instr_done = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_next = FETCH;
                end else if (wait_expired) begin
                    state_next = TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            REXEC: begin
                ctl.ALUSrcA = 1'b1;
                ctl.ALUSrcB = SRCB_RT;
                ctl.ALUOp   = ALUOP_FUNCT;
                regdst_next = 1'b1;
                state_next  = ALUWB;
            end
            IEXEC: begin
                ctl.ALUSrcA = 1'b1;
                ctl.ALUSrcB = SRCB_IMM;
                ctl.ALUOp   = ALUOP_ITYPE;
                regdst_next = 1'b0;
                state_next  = ALUWB;
            end
            ALUWB: begin
                ctl.RegWrite   = 1'b1;
                ctl.RegDst     = regdst_reg;
                ctl.instr_done = 1'b1;
                state_next     = FETCH;
            end
            BRANCH: begin
                ctl.ALUSrcA     = 1'b1;
                ctl.ALUSrcB     = SRCB_RT;
                ctl.ALUOp       = ALUOP_SUB;
                ctl.PCWriteCond = 1'b1;
                ctl.PCSource    = PCSRC_ALUOUT;
                ctl.PCCondNe    = (op == OP_BNE);
                ctl.instr_done  = 1'b1;
                state_next      = FETCH;
            end
            JUMP: begin
                ctl.PCWrite    = 1'b1;
                ctl.PCSource   = PCSRC_JUMP;
                ctl.instr_done = 1'b1;
                state_next     = FETCH;
            end
            TRAP: ctl.trap = 1'b1;
            default: state_next = IDLE;
        endcase
        // cause_reg is only non-zero after a trap and is cleared only by reset.
        ctl.trap_cause = cause_reg;
    end

    assign wait_en  = is_mem_state(state_reg) && !bus.mem_ready;
    assign wait_clr = is_mem_state(state_next) && (state_next != state_reg);

    mips_mc_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (wait_clr),
        .en      (wait_en),
        .expired (wait_expired)
    );

    assign bus.PCWrite     = ctl.PCWrite;
    assign bus.PCWriteCond = ctl.PCWriteCond;
    assign bus.PCCondNe    = ctl.PCCondNe;
    assign bus.IorD        = ctl.IorD;
    assign bus.MemRead     = ctl.MemRead;
    assign bus.MemWrite    = ctl.MemWrite;
    assign bus.IRWrite     = ctl.IRWrite;
    assign bus.MemtoReg    = ctl.MemtoReg;
    assign bus.RegWrite    = ctl.RegWrite;
    assign bus.RegDst      = ctl.RegDst;
    assign bus.ALUSrcA     = ctl.ALUSrcA;
    assign bus.ALUSrcB     = ctl.ALUSrcB;
    assign bus.ALUOp       = ctl.ALUOp;
    assign bus.PCSource    = ctl.PCSource;
    assign bus.instr_done  = ctl.instr_done;
    assign bus.trap        = ctl.trap;
    assign bus.trap_cause  = ctl.trap_cause;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: scoreboard bench for mips_mc_ctrl (MEM_TIMEOUT = 4).
// Each test plans per-cycle stimulus and pushes the expected control word for
// that cycle; the cycle is then driven and the popped expectation compared.
module tb_mips_mc_ctrl;
    localparam int TB_TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_mc_ctrl_if #(.OPW(6)) bus ();

    mips_mc_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .OPW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum {
        T_IDLE, T_FETCH, T_DECODE, T_MEMADDR, T_MEMRD, T_MEMWB, T_MEMWR,
        T_REXEC, T_IEXEC, T_ALUWB, T_BRANCH, T_JUMP, T_TRAP
    } tstate_t;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       PCCondNe;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       MemtoReg;
        logic       RegWrite;
        logic       RegDst;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic [1:0] PCSource;
        logic       instr_done;
        logic       trap;
        logic [1:0] trap_cause;
    } ctl_t;

    typedef struct {
        tstate_t    st;
        logic       rst;
        logic       run;
        logic       rdy;
        logic [5:0] op;
        ctl_t       exp;
    } rec_t;

    rec_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    // Expected outputs for one cycle in state st. aux is RegDst (ALUWB) or
    // the trap cause (TRAP).
    function automatic ctl_t model(tstate_t st, logic rdy, logic [5:0] op, logic [1:0] aux);
        ctl_t c;
        c = '0;
        case (st)
            T_FETCH:   begin c.MemRead = 1; c.ALUSrcB = 2'b01; c.IRWrite = rdy; c.PCWrite = rdy; end
            T_DECODE:  c.ALUSrcB = 2'b11;
            T_MEMADDR: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
            T_MEMRD:   begin c.MemRead = 1; c.IorD = 1; end
            T_MEMWB:   begin c.RegWrite = 1; c.MemtoReg = 1; c.instr_done = 1; end
            T_MEMWR:   begin c.MemWrite = 1; c.IorD = 1; c.instr_done = rdy; end
            T_REXEC:   begin c.ALUSrcA = 1; c.ALUOp = 2'b10; end
            T_IEXEC:   begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; c.ALUOp = 2'b11; end
            T_ALUWB:   begin c.RegWrite = 1; c.RegDst = aux[0]; c.instr_done = 1; end
            T_BRANCH:  begin
                c.ALUSrcA = 1; c.ALUOp = 2'b01; c.PCWriteCond = 1; c.PCSource = 2'b01;
                c.PCCondNe = (op == 6'b000101); c.instr_done = 1;
            end
            T_JUMP:    begin c.PCWrite = 1; c.PCSource = 2'b10; c.instr_done = 1; end
            T_TRAP:    begin c.trap = 1; c.trap_cause = aux; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    task automatic plan(tstate_t st, logic r, logic run, logic rdy, logic [5:0] op, logic [1:0] aux);
        rec_t rec;
        rec.st  = st;
        rec.rst = r;
        rec.run = run;
        rec.rdy = rdy;
        rec.op  = op;
        rec.exp = model(st, rdy, op, aux);
        sbq.push_back(rec);
    endtask

    function automatic ctl_t observe();
        ctl_t o;
        o.PCWrite     = bus.PCWrite;
        o.PCWriteCond = bus.PCWriteCond;
        o.PCCondNe    = bus.PCCondNe;
        o.IorD        = bus.IorD;
        o.MemRead     = bus.MemRead;
        o.MemWrite    = bus.MemWrite;
        o.IRWrite     = bus.IRWrite;
        o.MemtoReg    = bus.MemtoReg;
        o.RegWrite    = bus.RegWrite;
        o.RegDst      = bus.RegDst;
        o.ALUSrcA     = bus.ALUSrcA;
        o.ALUSrcB     = bus.ALUSrcB;
        o.ALUOp       = bus.ALUOp;
        o.PCSource    = bus.PCSource;
        o.instr_done  = bus.instr_done;
        o.trap        = bus.trap;
        o.trap_cause  = bus.trap_cause;
        return o;
    endfunction

    // Pop the next planned cycle, drive it after the falling edge, sample 1ns later.
    task automatic drive_next(output rec_t r, output ctl_t got);
        r = sbq.pop_front();
        @(negedge clk);
        rst           = r.rst;
        bus.run       = r.run;
        bus.mem_ready = r.rdy;
        bus.opcode    = r.op;
        #1;
        got = observe();
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'b0;
        bus.zero      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rec_t r; ctl_t got; int cyc = 0;
        apply_reset();
        plan(T_IDLE, 0, 0, 0, 6'b000000, 2'b00);
        plan(T_IDLE, 0, 0, 1, 6'b100011, 2'b00);
        plan(T_IDLE, 0, 0, 1, 6'b111111, 2'b00);
        while (sbq.size() > 0) begin
            drive_next(r, got); cyc++;
            checks++;
            if (got !== r.exp) $display("FAIL reset_idle %s cyc%0d: got %h required %h", r.st.name(), cyc, got, r.exp);
            else passed++;
        end
        $display("reset: %0d idle cycles checked", cyc);
    endtask

    task automatic test_rtype();
        rec_t r; ctl_t got; int cyc = 0, ndone = 0, first_done = 0;
        apply_reset();
        plan(T_IDLE,  0, 1, 1, 6'b000000, 2'b00);
        plan(T_FETCH, 0, 0, 1, 6'b000000, 2'b00);
        plan(T_DECODE,0, 0, 1, 6'b000000, 2'b00);
        plan(T_REXEC, 0, 0, 1, 6'b000000, 2'b00);
        plan(T_ALUWB, 0, 0, 1, 6'b000000, 2'b01);
        while (sbq.size() > 0) begin
            drive_next(r, got); cyc++;
            if (got.instr_done === 1'b1) begin ndone++; if (first_done == 0) first_done = cyc; end
            checks++;
            if (got !== r.exp) $display("FAIL rtype %s cyc%0d: got %h required %h", r.st.name(), cyc, got, r.exp);
            else passed++;
        end
        checks++;
        if (first_done !== 5) $display("FAIL rtype_done_cycle: got %0d required 5", first_done);
        else passed++;
        $display("rtype: retired %0d, instr_done at cycle %0d", ndone, first_done);
    endtask

    task automatic test_lw_wait();
        rec_t r; ctl_t got; int cyc = 0, first_done = 0, rd_cycles = 0;
        apply_reset();
        plan(T_IDLE,    0, 1, 1, 6'b000000, 2'b00);
        plan(T_FETCH,   0, 0, 1, 6'b000000, 2'b00);
        plan(T_DECODE,  0, 0, 1, 6'b100011, 2'b00);
        plan(T_MEMADDR, 0, 0, 1, 6'b100011, 2'b00);
        for (int i = 0; i < 3; i++) plan(T_MEMRD, 0, 0, 0, 6'b100011, 2'b00);
        plan(T_MEMRD,   0, 0, 1, 6'b100011, 2'b00);
        plan(T_MEMWB,   0, 0, 1, 6'b100011, 2'b00);
        while (sbq.size() > 0) begin
            drive_next(r, got); cyc++;
            if (got.instr_done === 1'b1 && first_done == 0) first_done = cyc;
            if (got.MemRead === 1'b1 && got.IorD === 1'b1) rd_cycles++;
            checks++;
            if (got !== r.exp) $display("FAIL lw_wait %s cyc%0d: got %h required %h", r.st.name(), cyc, got, r.exp);
            else passed++;
        end
        // FETCH is cycle 2, so an 8-cycle instruction completes in cycle 9.
        checks++;
        if (first_done !== 9) $display("FAIL lw_latency: got done at %0d required 9", first_done);
        else passed++;
        checks++;
        if (rd_cycles !== 4) $display("FAIL lw_memrd_cycles: got %0d required 4", rd_cycles);
        else passed++;
        $display("lw: done at cycle %0d, %0d data-read cycles", first_done, rd_cycles);
    endtask

    task automatic test_itype_back_to_back();
        rec_t r; ctl_t got; int cyc = 0, ndone = 0;
        apply_reset();
        plan(T_IDLE,   0, 1, 1, 6'b000000, 2'b00);
        plan(T_FETCH,  0, 0, 1, 6'b000000, 2'b00);
        plan(T_DECODE, 0, 0, 1, 6'b001101, 2'b00);
        plan(T_IEXEC,  0, 0, 1, 6'b001101, 2'b00);
        plan(T_ALUWB,  0, 0, 1, 6'b001101, 2'b00);
        plan(T_FETCH,  0, 0, 1, 6'b001101, 2'b00);
        plan(T_DECODE, 0, 0, 1, 6'b000010, 2'b00);
        plan(T_JUMP,   0, 0, 1, 6'b000010, 2'b00);
        plan(T_FETCH,  0, 0, 0, 6'b000010, 2'b00);
        while (sbq.size() > 0) begin
            drive_next(r, got); cyc++;
            if (got.instr_done === 1'b1) ndone++;
            checks++;
            if (got !== r.exp) $display("FAIL itype_b2b %s cyc%0d: got %h required %h", r.st.name(), cyc, got, r.exp);
            else passed++;
        end
        checks++;
        if (ndone !== 2) $display("FAIL itype_b2b_retired: got %0d required 2", ndone);
        else passed++;
        $display("ori+j: retired %0d", ndone);
    endtask

    task automatic test_branch_sw();
        rec_t r; ctl_t got; int cyc = 0, ndone = 0;
        apply_reset();
        plan(T_IDLE,    0, 1, 1, 6'b000000, 2'b00);
        plan(T_FETCH,   0, 0, 1, 6'b000000, 2'b00);
        plan(T_DECODE,  0, 0, 1, 6'b000101, 2'b00);
        plan(T_BRANCH,  0, 0, 1, 6'b000101, 2'b00);
        plan(T_FETCH,   0, 0, 1, 6'b000101, 2'b00);
        plan(T_DECODE,  0, 0, 1, 6'b000100, 2'b00);
        plan(T_BRANCH,  0, 0, 1, 6'b000100, 2'b00);
        plan(T_FETCH,   0, 0, 1, 6'b000100, 2'b00);
        plan(T_DECODE,  0, 0, 1, 6'b101011, 2'b00);
        plan(T_MEMADDR, 0, 0, 1, 6'b101011, 2'b00);
        plan(T_MEMWR,   0, 0, 0, 6'b101011, 2'b00);
        plan(T_MEMWR,   0, 0, 1, 6'b101011, 2'b00);
        plan(T_FETCH,   0, 0, 0, 6'b101011, 2'b00);
        while (sbq.size() > 0) begin
            drive_next(r, got); cyc++;
            if (got.instr_done === 1'b1) ndone++;
            checks++;
            if (got !== r.exp) $display("FAIL branch_sw %s cyc%0d: got %h required %h", r.st.name(), cyc, got, r.exp);
            else passed++;
        end
        checks++;
        if (ndone !== 3) $display("FAIL branch_sw_retired: got %0d required 3", ndone);
        else passed++;
        $display("bne+beq+sw: retired %0d", ndone);
    endtask

    task automatic test_timeout_illegal();
        rec_t r; ctl_t got; int cyc = 0, ndone = 0;
        apply_reset();
        plan(T_IDLE,   0, 1, 0, 6'b000000, 2'b00);
        for (int i = 0; i < TB_TIMEOUT; i++) plan(T_FETCH, 0, 0, 0, 6'b000000, 2'b00);
        plan(T_TRAP,   0, 0, 1, 6'b000000, 2'b10);
        plan(T_TRAP,   0, 1, 0, 6'b000000, 2'b10);
        plan(T_TRAP,   1, 0, 0, 6'b000000, 2'b10);
        plan(T_IDLE,   0, 1, 0, 6'b000000, 2'b00);
        // Ready arriving on the last permitted wait cycle wins over the trap.
        for (int i = 0; i < TB_TIMEOUT - 1; i++) plan(T_FETCH, 0, 0, 0, 6'b000000, 2'b00);
        plan(T_FETCH,  0, 0, 1, 6'b000000, 2'b00);
        plan(T_DECODE, 0, 0, 1, 6'b111111, 2'b00);
        plan(T_TRAP,   0, 0, 1, 6'b111111, 2'b01);
        plan(T_TRAP,   0, 1, 1, 6'b000000, 2'b01);
        while (sbq.size() > 0) begin
            drive_next(r, got); cyc++;
            if (got.instr_done === 1'b1) ndone++;
            checks++;
            if (got !== r.exp) $display("FAIL timeout_illegal %s cyc%0d: got %h required %h", r.st.name(), cyc, got, r.exp);
            else passed++;
        end
        checks++;
        if (ndone !== 0) $display("FAIL timeout_illegal_retired: got %0d required 0", ndone);
        else passed++;
        $display("timeout/illegal: %0d cycles, retired %0d", cyc, ndone);
    endtask

    task automatic test_reset_mid_wait();
        rec_t r; ctl_t got; int cyc = 0, ndone = 0;
        apply_reset();
        plan(T_IDLE,    0, 1, 1, 6'b000000, 2'b00);
        plan(T_FETCH,   0, 0, 1, 6'b000000, 2'b00);
        plan(T_DECODE,  0, 0, 1, 6'b101011, 2'b00);
        plan(T_MEMADDR, 0, 0, 1, 6'b101011, 2'b00);
        plan(T_MEMWR,   0, 0, 0, 6'b101011, 2'b00);
        plan(T_MEMWR,   1, 0, 0, 6'b101011, 2'b00);
        plan(T_IDLE,    0, 0, 1, 6'b101011, 2'b00);
        plan(T_IDLE,    0, 0, 1, 6'b101011, 2'b00);
        while (sbq.size() > 0) begin
            drive_next(r, got); cyc++;
            if (got.instr_done === 1'b1) ndone++;
            checks++;
            if (got !== r.exp) $display("FAIL reset_mid_wait %s cyc%0d: got %h required %h", r.st.name(), cyc, got, r.exp);
            else passed++;
        end
        checks++;
        if (ndone !== 0) $display("FAIL reset_mid_wait_retired: got %0d required 0", ndone);
        else passed++;
        $display("sw reset mid-wait: retired %0d", ndone);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_itype_back_to_back();
        test_branch_sw();
        test_timeout_illegal();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
